stagectrl: RTL and testbench

Pipeline stage controller that sequences the enable/clear register bank of an in-order pipeline. It merges per-stage stall and flush requests into per-stage `Stall` (drives the register's active-low enable) and `Flush` (drives the register's clear) outputs, inserts bubbles, and runs a fixed-latency multicycle-operation FSM for one stage. It sits beside the hazard logic and drives every stage register directly.

---
 rtl/stagectrl_if.sv | 25 ++
 rtl/stagectrl.sv | 162 ++++++++++++++++
 tb/tb_stagectrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/stagectrl_if.sv
// Stage-controller handshake bundle: per-stage stall/flush requests in,
// register-bank enable/clear controls and multicycle status out.
interface stagectrl_if #(
    parameter int STAGES = 5
);
    logic [STAGES-1:0] StallReq;
    logic [STAGES-1:0] FlushReq;
    logic              MCStart;
    logic [STAGES-1:0] Stall;
    logic [STAGES-1:0] Flush;
    logic              MCBusy;
    logic              MCDone;
    logic [31:0]       StallCycles;

    // master is the hazard-logic side, slave is the controller itself
    modport master (
        output StallReq, FlushReq, MCStart,
        input  Stall, Flush, MCBusy, MCDone, StallCycles
    );

    modport slave (
        input  StallReq, FlushReq, MCStart,
        output Stall, Flush, MCBusy, MCDone, StallCycles
    );
endinterface

// File: rtl/stagectrl.sv
// Pipeline stage controller: merges stall/flush requests, inserts bubbles and
// runs the fixed-latency multicycle FSM. Define STAGECTRL_PERF_EN for the stall counter.
module stagectrl #(
    parameter int STAGES  = 5,
    parameter int MCSTAGE = 2,
    parameter int MCLAT   = 4
) (
    input logic        clk,
    input logic        reset,
    stagectrl_if.slave bus
);

    localparam int CW = $clog2(MCLAT) + 1;

    if (MCLAT < 2) begin : g_bad_mclat
        $error("stagectrl: MCLAT must be at least 2");
    end
    if (MCSTAGE < 0 || MCSTAGE > STAGES - 2) begin : g_bad_mcstage
        $error("stagectrl: MCSTAGE must lie in 0..STAGES-2");
    end

    typedef enum logic [1:0] {
        MC_IDLE,
        MC_BUSY,
        MC_DONE
    } mc_state_e;

    mc_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [STAGES-1:0] flush_cover;
    logic [STAGES-1:0] stall_cause;
    logic [STAGES-1:0] stall_prop;
    logic [STAGES-1:0] stall;
    logic [STAGES-1:0] bubble;
    logic [STAGES-1:0] flush;
    logic              mc_stall_active;

    // A flush request at stage i also discards every younger stage below it.
    always_comb begin
        logic acc;
        acc         = 1'b0;
        flush_cover = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc            = acc | bus.FlushReq[i];
            flush_cover[i] = acc;
        end
    end

    // The start cycle already stalls, so the op occupies R[MCSTAGE] for MCLAT cycles.
    always_comb begin
        mc_stall_active = 1'b0;
        if (state_q == MC_BUSY) begin
            mc_stall_active = 1'b1;
        end else if (state_q == MC_IDLE && bus.MCStart && !flush_cover[MCSTAGE]) begin
            mc_stall_active = 1'b1;
        end
    end

    always_comb begin
        logic acc;
        acc         = 1'b0;
        stall_cause = bus.StallReq;
        stall_cause[MCSTAGE] = bus.StallReq[MCSTAGE] | mc_stall_active;
        stall_prop  = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc           = acc | stall_cause[i];
            stall_prop[i] = acc;
        end
    end

    // Flush wins over stall; a held stage feeds a bubble to the register after it.
    always_comb begin
        stall  = stall_prop & ~flush_cover;
        bubble = '0;
        for (int i = 1; i < STAGES; i++) begin
            bubble[i] = stall[i-1] & ~stall[i];
        end
        flush = flush_cover | bubble;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MC_IDLE: begin
                if (bus.MCStart && !flush_cover[MCSTAGE]) begin
                    state_d = MC_BUSY;
                    cnt_d   = CW'(MCLAT - 1);
                end
            end
            MC_BUSY: begin
                if (flush_cover[MCSTAGE]) begin
                    state_d = MC_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= CW'(1)) begin
                    state_d = MC_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - CW'(1);
                end
            end
            MC_DONE: begin
                if (flush_cover[MCSTAGE] || !stall[MCSTAGE]) begin
                    state_d = MC_IDLE;
                end
            end
            default: begin
                state_d = MC_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == MC_BUSY);
        done_d = (state_d == MC_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MC_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef STAGECTRL_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    // Saturating count of cycles in which fetch was held.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall[0] && stall_cycles_q != 32'hFFFF_FFFF) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.StallCycles = stall_cycles_q;
`else
    assign bus.StallCycles = 32'd0;
`endif

    assign bus.Stall  = stall;
    assign bus.Flush  = flush;
    assign bus.MCBusy = busy_q;
    assign bus.MCDone = done_q;

endmodule

// File: tb/tb_stagectrl.sv
// Scoreboard bench for stagectrl: each driven cycle pushes its expected outputs,
// a negedge monitor pops and compares them.
module tb_stagectrl;

    logic clk;
    logic reset;

    stagectrl_if #(.STAGES(5)) bus ();

    stagectrl #(
        .STAGES (5),
        .MCSTAGE(2),
        .MCLAT  (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

`ifdef STAGECTRL_PERF_EN
    localparam logic [31:0] PERF_TEN = 32'd10;
`else
    localparam logic [31:0] PERF_TEN = 32'd0;
`endif

    typedef struct {
        string       tag;
        logic        chk;
        logic [4:0]  stall;
        logic [4:0]  flush;
        logic        busy;
        logic        done;
        logic        chk_cyc;
        logic [31:0] cycles;
    } exp_t;

    exp_t exp_q[$];
    int   assert_count = 0;
    int   fail_count   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic rst,
                                 input logic [4:0] sreq, input logic [4:0] freq,
                                 input logic mcs, input logic chk,
                                 input logic [4:0] e_stall, input logic [4:0] e_flush,
                                 input logic e_busy, input logic e_done,
                                 input logic chk_cyc, input logic [31:0] e_cyc);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = rst;
        bus.StallReq = sreq;
        bus.FlushReq = freq;
        bus.MCStart  = mcs;
        e.tag     = tag;
        e.chk     = chk;
        e.stall   = e_stall;
        e.flush   = e_flush;
        e.busy    = e_busy;
        e.done    = e_done;
        e.chk_cyc = chk_cyc;
        e.cycles  = e_cyc;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.chk) begin
                checkOutput({e.tag, ".Stall"},  32'(bus.Stall),  32'(e.stall));
                checkOutput({e.tag, ".Flush"},  32'(bus.Flush),  32'(e.flush));
                checkOutput({e.tag, ".MCBusy"}, 32'(bus.MCBusy), 32'(e.busy));
                checkOutput({e.tag, ".MCDone"}, 32'(bus.MCDone), 32'(e.done));
            end
            if (e.chk_cyc) begin
                checkOutput({e.tag, ".StallCycles"}, bus.StallCycles, e.cycles);
            end
        end
    end

    initial begin
        reset        = 1'b1;
        bus.StallReq = '0;
        bus.FlushReq = '0;
        bus.MCStart  = 1'b0;

        // reset
        applyStimulus("rst0", 1, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0);
        applyStimulus("rst1", 1, 5'b00000, 5'b00000, 0, 1, 5'b00000, 5'b00000, 0, 0, 1, 0);

        // combinational merge
        applyStimulus("comb_s2",    0, 5'b00100, 5'b00000, 0, 1, 5'b00111, 5'b01000, 0, 0, 0, 0);
        applyStimulus("comb_s2f1",  0, 5'b00100, 5'b00010, 0, 1, 5'b00100, 5'b01011, 0, 0, 0, 0);
        applyStimulus("comb_s4",    0, 5'b10000, 5'b00000, 0, 1, 5'b11111, 5'b00000, 0, 0, 0, 0);
        applyStimulus("comb_f4",    0, 5'b00000, 5'b10000, 0, 1, 5'b00000, 5'b11111, 0, 0, 0, 0);
        applyStimulus("comb_sf3",   0, 5'b01000, 5'b01000, 0, 1, 5'b00000, 5'b01111, 0, 0, 0, 0);
        applyStimulus("comb_s0",    0, 5'b00001, 5'b00000, 0, 1, 5'b00001, 5'b00010, 0, 0, 0, 0);
        applyStimulus("comb_idle",  0, 5'b00000, 5'b00000, 0, 1, 5'b00000, 5'b00000, 0, 0, 0, 0);

        // plain multicycle op; a second MCStart while busy is ignored
        applyStimulus("mc_c0", 0, 5'b00000, 5'b00000, 1, 1, 5'b00111, 5'b01000, 0, 0, 0, 0);
        applyStimulus("mc_c1", 0, 5'b00000, 5'b00000, 0, 1, 5'b00111, 5'b01000, 1, 0, 0, 0);
        applyStimulus("mc_c2", 0, 5'b00000, 5'b00000, 1, 1, 5'b00111, 5'b01000, 1, 0, 0, 0);
        applyStimulus("mc_c3", 0, 5'b00000, 5'b00000, 0, 1, 5'b00111, 5'b01000, 1, 0, 0, 0);
        applyStimulus("mc_c4", 0, 5'b00000, 5'b00000, 0, 1, 5'b00000, 5'b00000, 0, 1, 0, 0);
        applyStimulus("mc_c5", 0, 5'b00000, 5'b00000, 0, 1, 5'b00000, 5'b00000, 0, 0, 0, 0);

        // abort by an older flush in cycle 2
        applyStimulus("ab_c0", 0, 5'b00000, 5'b00000, 1, 1, 5'b00111, 5'b01000, 0, 0, 0, 0);
        applyStimulus("ab_c1", 0, 5'b00000, 5'b00000, 0, 1, 5'b00111, 5'b01000, 1, 0, 0, 0);
        applyStimulus("ab_c2", 0, 5'b00000, 5'b01000, 0, 1, 5'b00000, 5'b01111, 1, 0, 0, 0);
        applyStimulus("ab_c3", 0, 5'b00000, 5'b00000, 0, 1, 5'b00000, 5'b00000, 0, 0, 0, 0);
        applyStimulus("ab_c4", 0, 5'b00000, 5'b00000, 0, 1, 5'b00000, 5'b00000, 0, 0, 0, 0);

        // older stall across the end of BUSY holds DONE
        applyStimulus("hd_c0", 0, 5'b00000, 5'b00000, 1, 1, 5'b00111, 5'b01000, 0, 0, 0, 0);
        applyStimulus("hd_c1", 0, 5'b00000, 5'b00000, 0, 1, 5'b00111, 5'b01000, 1, 0, 0, 0);
        applyStimulus("hd_c2", 0, 5'b00000, 5'b00000, 0, 1, 5'b00111, 5'b01000, 1, 0, 0, 0);
        applyStimulus("hd_c3", 0, 5'b10000, 5'b00000, 0, 1, 5'b11111, 5'b00000, 1, 0, 0, 0);
        applyStimulus("hd_c4", 0, 5'b10000, 5'b00000, 0, 1, 5'b11111, 5'b00000, 0, 1, 0, 0);
        applyStimulus("hd_c5", 0, 5'b10000, 5'b00000, 0, 1, 5'b11111, 5'b00000, 0, 1, 0, 0);
        applyStimulus("hd_c6", 0, 5'b10000, 5'b00000, 0, 1, 5'b11111, 5'b00000, 0, 1, 0, 0);
        applyStimulus("hd_c7", 0, 5'b00000, 5'b00000, 0, 1, 5'b00000, 5'b00000, 0, 1, 0, 0);
        applyStimulus("hd_c8", 0, 5'b00000, 5'b00000, 0, 1, 5'b00000, 5'b00000, 0, 0, 0, 0);

        // reset while busy
        applyStimulus("rb_c0", 0, 5'b00000, 5'b00000, 1, 1, 5'b00111, 5'b01000, 0, 0, 0, 0);
        applyStimulus("rb_c1", 0, 5'b00000, 5'b00000, 0, 1, 5'b00111, 5'b01000, 1, 0, 0, 0);
        applyStimulus("rb_c2", 1, 5'b00000, 5'b00000, 0, 1, 5'b00111, 5'b01000, 1, 0, 0, 0);
        applyStimulus("rb_c3", 0, 5'b00000, 5'b00000, 0, 1, 5'b00000, 5'b00000, 0, 0, 0, 0);
        applyStimulus("rb_c4", 0, 5'b00000, 5'b00000, 0, 1, 5'b00000, 5'b00000, 0, 0, 0, 0);

        // MCStart together with a flush covering the stage is dropped
        applyStimulus("sf_c0", 0, 5'b00000, 5'b00100, 1, 1, 5'b00000, 5'b00111, 0, 0, 0, 0);
        applyStimulus("sf_c1", 0, 5'b00000, 5'b00000, 0, 1, 5'b00000, 5'b00000, 0, 0, 0, 0);

        // stall-cycle counter
        applyStimulus("pf_rst", 1, 5'b00000, 5'b00000, 0, 1, 5'b00000, 5'b00000, 0, 0, 0, 0);
        applyStimulus("pf_s0",  0, 5'b00001, 5'b00000, 0, 1, 5'b00001, 5'b00010, 0, 0, 1, 0);
        for (int k = 1; k < 10; k++) begin
            applyStimulus("pf_s", 0, 5'b00001, 5'b00000, 0, 1, 5'b00001, 5'b00010, 0, 0, 0, 0);
        end
        applyStimulus("pf_ten",  0, 5'b00000, 5'b00000, 0, 1, 5'b00000, 5'b00000, 0, 0, 1, PERF_TEN);
        applyStimulus("pf_rsta", 1, 5'b00000, 5'b00000, 0, 1, 5'b00000, 5'b00000, 0, 0, 1, PERF_TEN);
        applyStimulus("pf_clr",  0, 5'b00000, 5'b00000, 0, 1, 5'b00000, 5'b00000, 0, 0, 1, 0);

        for (int k = 0; k < 4 && exp_q.size() > 0; k++) begin
            @(negedge clk);
        end
        #1;
        checkOutput("drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
